accum_bank: RTL
===============

Name: accum_bank

Overview:
- Multi-lane successor to the single-lane accumulator.
- NUM_LANES independent accumulator lanes share one address, op and valid stream; each lane owns a DEPTH x ACCUM_DATAW BRAM slice.
- Adds read-after-write forwarding, so back-to-back ops to the same address are correct, and emits the result address with each output.
- Sits after the dot-product slices in the MVU datapath, feeding the output FIFO / activation stage.

Parameters:
- NUM_LANES, 4, number of parallel accumulator lanes.
- IN_DATAW, 26, signed input width per lane.
- ACCUM_DATAW, 32, signed accumulator/output width per lane; must be >= IN_DATAW.
- ACCUM_DEPTH, 512, entries per lane.
- ACCUM_ADDRW, $clog2(ACCUM_DEPTH), address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  op valid this cycle; no backpressure.
- i_addr  in  ACCUM_ADDRW  accumulator entry.
- i_op  in  2  0=SET, 1=ADD, 2=ADD_OUT, 3=SET_OUT.
- i_data  in  NUM_LANES*IN_DATAW  lane k at bits [k*IN_DATAW +: IN_DATAW], signed.
- o_valid  out  1  result valid.
- o_addr  out  ACCUM_ADDRW  address of the emitted result.
- o_data  out  NUM_LANES*ACCUM_DATAW  lane k at [k*ACCUM_DATAW +: ACCUM_DATAW].

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: o_valid=0, o_addr=0, o_data=0. All in-flight pipeline valids are cleared.
- BRAM contents are not reset; the first op to any address after reset must be SET or SET_OUT.
- Pipeline: the op accepted at cycle t issues its BRAM read at t. BRAM read latency is 2 cycles.
- Result is computed and registered in cycle t+3; the write commits at the t+3 edge.
- o_valid/o_addr/o_data are valid during t+3, fixed latency 3.
- Writes are issued only for valid ops; ops with i_valid=0 never write.
- Per-lane arithmetic:
  - Input is sign-extended to ACCUM_DATAW.
  - SET/SET_OUT: new = ext(in).
  - ADD/ADD_OUT: new = ext(in) + old, wrapping modulo 2^ACCUM_DATAW unless the optional feature is enabled.
- o_valid=1 only for valid ADD_OUT/SET_OUT. The entry is still written back: OUT does not clear.
- o_data holds the last computed value when o_valid=0; only o_valid is qualified.
- Forwarding:
  - "old" is the BRAM read, replaced by the result of the youngest valid in-flight op to the same address issued 1, 2 or 3 cycles earlier.
  - Priority order: distance 1 > 2 > 3.
  - Ops 4+ cycles apart read committed BRAM data.
  - BRAM read-during-write to the same address returns old data; the forwarding path covers this case.
- Full-rate: one op per cycle sustained, any address sequence, including the same address every cycle.
- Reset mid-operation: ops issued up to 3 cycles before reset are dropped. Their writes and outputs are suppressed from the reset cycle onward.
- Address wrap: i_addr is used as-is; no bounds check. With non-power-of-2 ACCUM_DEPTH, out-of-range addresses are undefined.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: ADD/ADD_OUT clamp per lane to [-2^(ACCUM_DATAW-1), 2^(ACCUM_DATAW-1)-1] on signed overflow. Forwarded values are the clamped values.
- Undefined: two's-complement wrap, with no extra logic.

Test Plan:
- Reset, then SET addr 5 lanes {1,2,3,4}; ADD_OUT addr 5 lanes {10,20,30,40} at t+4 -> o_valid at t+7, o_addr=5, o_data={11,22,33,44}.
- Back-to-back same address: SET 7 {1}, then ADD 7 {1} on 3 consecutive cycles, then ADD_OUT 7 {1} -> output 5 in every lane, with o_valid high for exactly 1 cycle.
- Interleaved addresses: SET 0, SET 1, ADD 0, ADD 1, ADD_OUT 0, ADD_OUT 1 with values 2,3,4,5,6,7 -> outputs addr 0 = 12, addr 1 = 15, on consecutive cycles.
- Negative and sign extension: SET 3 {-5 (26-bit)}, ADD_OUT 3 {2} -> 32'hFFFFFFFD.
- Overflow: SET 9 {2^25-1}, 64 further ADDs of {2^25-1}, then ADD_OUT {0} -> wraps without the macro; equals 2^31-1 with ACCUM_SATURATE_EN.
- Reset mid-flight: SET_OUT 2 {8}, assert rst on the next cycle for 1 cycle -> no o_valid. A later SET_OUT 2 {1} outputs 1.

Source files
------------

// File: rtl/accum_bank.sv
// accum_bank: NUM_LANES BRAM accumulators sharing one op stream, with read-after-write forwarding.
// Define ACCUM_SATURATE_EN to clamp ADD results on signed overflow instead of wrapping.
module accum_bank #(
    parameter int NUM_LANES   = 4,
    parameter int IN_DATAW    = 26,
    parameter int ACCUM_DATAW = 32,
    parameter int ACCUM_DEPTH = 512,
    parameter int ACCUM_ADDRW = $clog2(ACCUM_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [ACCUM_ADDRW-1:0]           i_addr,
    input  logic [1:0]                       i_op,
    input  logic [NUM_LANES*IN_DATAW-1:0]    i_data,
    output logic                             o_valid,
    output logic [ACCUM_ADDRW-1:0]           o_addr,
    output logic [NUM_LANES*ACCUM_DATAW-1:0] o_data
);
    localparam int W = NUM_LANES * ACCUM_DATAW;
    logic                          v1_q, v2_q, v3_q, v4_q, v5_q, out3_q;
    logic [ACCUM_ADDRW-1:0]        a1_q, a2_q, a3_q, a4_q, a5_q;
    logic [1:0]                    op1_q, op2_q;
    logic [NUM_LANES*IN_DATAW-1:0] d1_q, d2_q;
    logic [W-1:0]                  res3_q, res4_q, res5_q, res3_d, fwd_data;
    logic                          hit1, hit2, hit3, fwd_en, is_add;

    // Youngest in-flight result to the same address replaces the (possibly stale) BRAM read.
    assign hit1     = v3_q && (a3_q == a2_q);
    assign hit2     = v4_q && (a4_q == a2_q);
    assign hit3     = v5_q && (a5_q == a2_q);
    assign fwd_en   = hit1 || hit2 || hit3;
    assign fwd_data = hit1 ? res3_q : hit2 ? res4_q : res5_q;
    assign is_add   = op2_q[0] ^ op2_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            v5_q   <= 1'b0;
            out3_q <= 1'b0;
            a3_q   <= '0;
            res3_q <= '0;
        end else begin
            v1_q   <= i_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            v4_q   <= v3_q;
            v5_q   <= v4_q;
            out3_q <= v2_q && op2_q[1];
            if (v2_q) begin
                a3_q   <= a2_q;
                res3_q <= res3_d;
            end
        end
        a1_q   <= i_addr;
        op1_q  <= i_op;
        d1_q   <= i_data;
        a2_q   <= a1_q;
        op2_q  <= op1_q;
        d2_q   <= d1_q;
        a4_q   <= a3_q;
        res4_q <= res3_q;
        a5_q   <= a4_q;
        res5_q <= res4_q;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [ACCUM_DATAW-1:0] mem [ACCUM_DEPTH];
        logic [ACCUM_DATAW-1:0] rd_q, old, ext, sum_w;
        always_ff @(posedge clk) begin
            rd_q <= mem[a1_q];
            if (v3_q && !rst) mem[a3_q] <= res3_q[k*ACCUM_DATAW +: ACCUM_DATAW];
        end
        assign old = fwd_en ? fwd_data[k*ACCUM_DATAW +: ACCUM_DATAW] : rd_q;
        assign ext = ACCUM_DATAW'($signed(d2_q[k*IN_DATAW +: IN_DATAW]));
`ifdef ACCUM_SATURATE_EN
        logic [ACCUM_DATAW:0] sum;
        assign sum   = {ext[ACCUM_DATAW-1], ext} + {old[ACCUM_DATAW-1], old};
        assign sum_w = (sum[ACCUM_DATAW] != sum[ACCUM_DATAW-1])
                     ? {sum[ACCUM_DATAW], {(ACCUM_DATAW-1){~sum[ACCUM_DATAW]}}}
                     : sum[ACCUM_DATAW-1:0];
`else
        assign sum_w = ext + old;
`endif
        assign res3_d[k*ACCUM_DATAW +: ACCUM_DATAW] = is_add ? sum_w : ext;
    end

    assign o_valid = out3_q && !rst;
    assign o_addr  = a3_q;
    assign o_data  = res3_q;
endmodule
